// File: rtl/accum_diff_decoder.sv
// Purpose : recovers Data samples from an accumulator's running-sum stream by
//           differencing consecutive sums modulo 2^WIDTH.
// Latency : one cycle from an accepted sum to DataValid with its difference.
// Backpr. : SumReady comes from the 2-entry output FIFO's registered occupancy
//           only, so it never follows DataReady combinationally.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Sync                upstream accumulator cleared; next accept decodes vs 0
//   SumIn/SumValid/SumReady      running-sum input link
//   DataOut/FirstOut/DataValid/DataReady  decoded sample output link (FIFO head)
//   SampleCount         saturating count of accepted sums since reset

// Two-entry FIFO used as the decoder's output buffer.
// Latency: a push is visible at the head on the next cycle when the FIFO is empty.
// Backpressure: push_rdy depends only on the registered occupancy.
module accum_diff_fifo #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  output logic          push_rdy,
  output logic          pop_vld,
  output logic [DW-1:0] pop_dat,
  input  logic          pop_rdy
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          push;
  logic          pop;

  assign push_rdy = (cnt < 2'd2);
  assign pop_vld  = (cnt != 2'd0);
  assign push     = push_vld & push_rdy;
  assign pop      = pop_vld & pop_rdy;

  // Head reads as zero while empty so the output is clean after reset.
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

module accum_diff_decoder #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Sync,
  input  logic [WIDTH-1:0]     SumIn,
  input  logic                 SumValid,
  output logic                 SumReady,
  output logic [WIDTH-1:0]     DataOut,
  output logic                 FirstOut,
  output logic                 DataValid,
  input  logic                 DataReady,
  output logic [CNT_WIDTH-1:0] SampleCount
);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             accept;
  logic             decode_first;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   fifo_in;
  logic [WIDTH:0]   fifo_out;

  assign accept       = SumValid & SumReady;

  // A Sync coinciding with an accept restarts decoding on that very sum.
  assign decode_first = Sync | (state == ST_FIRST);
  assign base         = decode_first ? '0 : prev;

  // Wrap-around subtraction; the borrow is deliberately dropped.
  assign diff         = SumIn - base;
  assign fifo_in      = {diff, decode_first};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_FIRST;
      prev  <= '0;
    end else if (accept) begin
      state <= ST_RUN;
      prev  <= SumIn;
    end else if (Sync) begin
      state <= ST_FIRST;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      SampleCount <= '0;
    end else if (accept && (SampleCount != '1)) begin
      SampleCount <= SampleCount + 1'b1;
    end
  end

  accum_diff_fifo #(
    .DW (WIDTH + 1)
  ) u_out_fifo (
    .clk      (Clock),
    .rst      (Reset),
    .push_vld (SumValid),
    .push_dat (fifo_in),
    .push_rdy (SumReady),
    .pop_vld  (DataValid),
    .pop_dat  (fifo_out),
    .pop_rdy  (DataReady)
  );

  assign DataOut  = fifo_out[WIDTH:1];
  assign FirstOut = fifo_out[0];

endmodule

// File: tb/tb_accum_diff_decoder.sv
// Purpose : directed self-checking bench for accum_diff_decoder (WIDTH=4).
// Latency : checks outputs #1 after each rising edge.
// Backpr. : exercises DataReady stalls and the SumReady hold-off.
module tb_accum_diff_decoder;

  localparam int WIDTH     = 4;
  localparam int CNT_WIDTH = 8;

  logic                 Clock;
  logic                 Reset;
  logic                 Sync;
  logic [WIDTH-1:0]     SumIn;
  logic                 SumValid;
  logic                 SumReady;
  logic [WIDTH-1:0]     DataOut;
  logic                 FirstOut;
  logic                 DataValid;
  logic                 DataReady;
  logic [CNT_WIDTH-1:0] SampleCount;

  int checks = 0;
  int errors = 0;

  accum_diff_decoder #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Sync        (Sync),
    .SumIn       (SumIn),
    .SumValid    (SumValid),
    .SumReady    (SumReady),
    .DataOut     (DataOut),
    .FirstOut    (FirstOut),
    .DataValid   (DataValid),
    .DataReady   (DataReady),
    .SampleCount (SampleCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    SumValid = 1'b0;
    Sync     = 1'b0;
    step();
    Reset    = 1'b0;
  endtask

  task automatic test_reset();
    SumIn     = '0;
    DataReady = 1'b1;
    do_reset();
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", DataValid); end
    checks++; if (DataOut !== 4'd0) begin errors++; $display("FAIL reset_data got %0d want 0", DataOut); end
    checks++; if (FirstOut !== 1'b0) begin errors++; $display("FAIL reset_first got %0b want 0", FirstOut); end
    checks++; if (SumReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", SumReady); end
    checks++; if (SampleCount !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", SampleCount); end
  endtask

  task automatic test_basic();
    logic [3:0] sums  [4] = '{4'd3, 4'd7, 4'd7, 4'd2};
    logic [3:0] exps  [4] = '{4'd3, 4'd4, 4'd0, 4'd11};
    logic       firsts[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    DataReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SumIn    = sums[i];
      SumValid = 1'b1;
      step();
      checks++; if (DataValid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %0b want 1", i, DataValid); end
      checks++; if (DataOut !== exps[i]) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", i, DataOut, exps[i]); end
      checks++; if (FirstOut !== firsts[i]) begin errors++; $display("FAIL basic_first[%0d] got %0b want %0b", i, FirstOut, firsts[i]); end
    end
    SumValid = 1'b0;
    step();
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", DataValid); end
    checks++; if (SampleCount !== 8'd4) begin errors++; $display("FAIL basic_count got %0d want 4", SampleCount); end
  endtask

  task automatic test_wrap();
    logic [3:0] sums[3] = '{4'd14, 4'd1, 4'd0};
    logic [3:0] exps[3] = '{4'd12, 4'd3, 4'd15};
    DataReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      SumIn    = sums[i];
      SumValid = 1'b1;
      step();
      checks++; if (DataOut !== exps[i] || FirstOut !== 1'b0 || DataValid !== 1'b1) begin
        errors++; $display("FAIL wrap[%0d] got d=%0d f=%0b v=%0b want d=%0d f=0 v=1", i, DataOut, FirstOut, DataValid, exps[i]);
      end
    end
    SumValid = 1'b0;
    step();
    checks++; if (SampleCount !== 8'd7) begin errors++; $display("FAIL wrap_count got %0d want 7", SampleCount); end
  endtask

  task automatic test_backpressure();
    // prev is 0 after the wrap test, so the diffs are 5, 1, 3.
    DataReady = 1'b0;
    SumValid  = 1'b1;
    SumIn     = 4'd5;
    step();
    checks++; if (DataOut !== 4'd5 || DataValid !== 1'b1) begin errors++; $display("FAIL bp_first got d=%0d v=%0b want d=5 v=1", DataOut, DataValid); end
    SumIn = 4'd6;
    step();
    checks++; if (SumReady !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", SumReady); end
    SumIn = 4'd9;
    step();
    step();
    checks++; if (DataOut !== 4'd5) begin errors++; $display("FAIL bp_stall_data got %0d want 5", DataOut); end
    checks++; if (SampleCount !== 8'd9) begin errors++; $display("FAIL bp_held_count got %0d want 9", SampleCount); end
    checks++; if (SumReady !== 1'b0) begin errors++; $display("FAIL bp_held_ready got %0b want 0", SumReady); end
    DataReady = 1'b1;
    step();
    checks++; if (DataOut !== 4'd1 || SumReady !== 1'b1) begin errors++; $display("FAIL bp_release got d=%0d r=%0b want d=1 r=1", DataOut, SumReady); end
    step();
    checks++; if (DataOut !== 4'd3 || DataValid !== 1'b1) begin errors++; $display("FAIL bp_third got d=%0d v=%0b want d=3 v=1", DataOut, DataValid); end
    SumValid = 1'b0;
    step();
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", DataValid); end
    checks++; if (SampleCount !== 8'd10) begin errors++; $display("FAIL bp_count got %0d want 10", SampleCount); end
  endtask

  task automatic test_sync();
    logic [3:0] sums  [4] = '{4'd4, 4'd12, 4'd9, 4'd5};
    logic       syncs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exps  [4] = '{4'd4, 4'd8, 4'd9, 4'd12};
    logic       firsts[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    DataReady = 1'b1;
    // Sync alone: no data produced, but the next sum decodes against zero.
    Sync     = 1'b1;
    SumValid = 1'b0;
    step();
    Sync = 1'b0;
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL sync_alone_valid got %0b want 0", DataValid); end
    for (int i = 0; i < 4; i++) begin
      SumIn    = sums[i];
      Sync     = syncs[i];
      SumValid = 1'b1;
      step();
      checks++; if (DataOut !== exps[i] || FirstOut !== firsts[i]) begin
        errors++; $display("FAIL sync[%0d] got d=%0d f=%0b want d=%0d f=%0b", i, DataOut, FirstOut, exps[i], firsts[i]);
      end
    end
    Sync     = 1'b0;
    SumValid = 1'b0;
    step();
    checks++; if (SampleCount !== 8'd14) begin errors++; $display("FAIL sync_count got %0d want 14", SampleCount); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    DataReady = 1'b1;
    SumValid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      SumIn = 4'(i);
      step();
    end
    DataReady = 1'b0;
    SumIn     = 4'd5;
    step();
    checks++; if (SumReady !== 1'b0 || SampleCount !== 8'd5) begin errors++; $display("FAIL mid_pre got r=%0b c=%0d want r=0 c=5", SumReady, SampleCount); end
    Reset    = 1'b1;
    SumValid = 1'b0;
    step();
    Reset = 1'b0;
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", DataValid); end
    checks++; if (SumReady !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", SumReady); end
    checks++; if (SampleCount !== 8'd0) begin errors++; $display("FAIL mid_count got %0d want 0", SampleCount); end
    DataReady = 1'b1;
    SumIn     = 4'd6;
    SumValid  = 1'b1;
    step();
    checks++; if (DataOut !== 4'd6 || FirstOut !== 1'b1 || DataValid !== 1'b1) begin
      errors++; $display("FAIL mid_after got d=%0d f=%0b v=%0b want d=6 f=1 v=1", DataOut, FirstOut, DataValid);
    end
    SumValid = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    logic [3:0] sum;
    logic [3:0] prev_m;
    logic [3:0] exp_d;
    int         exp_c;
    do_reset();
    DataReady = 1'b1;
    SumValid  = 1'b1;
    prev_m    = 4'd0;
    for (int i = 0; i < 300; i++) begin
      sum   = 4'((i * i + 3 * i) & 15);
      exp_d = sum - prev_m;
      prev_m = sum;
      exp_c = (i + 1 > 255) ? 255 : i + 1;
      SumIn = sum;
      step();
      checks++; if (DataOut !== exp_d || FirstOut !== (i == 0) || DataValid !== 1'b1) begin
        errors++; $display("FAIL sat_data[%0d] got d=%0d f=%0b v=%0b want d=%0d f=%0b", i, DataOut, FirstOut, DataValid, exp_d, (i == 0));
      end
      checks++; if (SampleCount !== 8'(exp_c)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, SampleCount, exp_c); end
    end
    SumValid = 1'b0;
    step();
  endtask

  initial begin
    Reset     = 1'b1;
    Sync      = 1'b0;
    SumIn     = '0;
    SumValid  = 1'b0;
    DataReady = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_sync();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
